// File: rtl/sd_edge_detect_multi_pkg.sv
`default_nettype none
//==============================================================================
// Package     : sd_edge_pkg
// Description : Shared types and constants for the multi-channel SD edge
//               detector: edge-mode encoding, edge counter width and the
//               filter counter width helper.
// Config      : SD_EDGE_CNT_EN (optional per-channel edge counters) uses
//               EDGE_CNT_W from this package.
// Revision    : 1.0 - initial release
//==============================================================================
package sd_edge_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_t;

    localparam int EDGE_CNT_W = 16;

    // The filter counter only has to reach FILT_CYCLES-1, but is sized for
    // FILT_CYCLES so the width never collapses to zero.
    function automatic int filt_cnt_w(input int filt_cycles);
        return (filt_cycles < 1) ? 1 : $clog2(filt_cycles + 1);
    endfunction

    function automatic logic mode_has_rise(input edge_mode_t mode);
        return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    endfunction

    function automatic logic mode_has_fall(input edge_mode_t mode);
        return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_edge_detect_multi_if.sv
`default_nettype none
//==============================================================================
// Interface   : sd_edge_detect_multi_if
// Description : Bundle between the SD pad side / control logic (master) and
//               the multi-channel edge detector (slave).
// Signals     : en, edge_mode[1:0], async_in[NUM_CH]            master -> slave
//               level_out, rise_pulse, fall_pulse, edge_pulse   slave -> master
//               cnt_clr / edge_cnt[NUM_CH*16] only with SD_EDGE_CNT_EN
// Config      : SD_EDGE_CNT_EN adds cnt_clr and edge_cnt.
// Revision    : 1.0 - initial release
//==============================================================================
interface sd_edge_detect_multi_if #(
    parameter int NUM_CH = 4
);
    import sd_edge_pkg::*;

    logic              en;
    logic [1:0]        edge_mode;
    logic [NUM_CH-1:0] async_in;
    logic [NUM_CH-1:0] level_out;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;
    logic [NUM_CH-1:0] edge_pulse;
`ifdef SD_EDGE_CNT_EN
    logic                         cnt_clr;
    logic [NUM_CH*EDGE_CNT_W-1:0] edge_cnt;

    modport master (
        output en, edge_mode, async_in, cnt_clr,
        input  level_out, rise_pulse, fall_pulse, edge_pulse, edge_cnt
    );
    modport slave (
        input  en, edge_mode, async_in, cnt_clr,
        output level_out, rise_pulse, fall_pulse, edge_pulse, edge_cnt
    );
`else
    modport master (
        output en, edge_mode, async_in,
        input  level_out, rise_pulse, fall_pulse, edge_pulse
    );
    modport slave (
        input  en, edge_mode, async_in,
        output level_out, rise_pulse, fall_pulse, edge_pulse
    );
`endif

endinterface
`default_nettype wire

// File: rtl/sd_edge_detect_multi_chan.sv
`default_nettype none
//==============================================================================
// Module      : sd_edge_chan
// Description : One channel of the SD edge detector: SYNC_STAGES-deep
//               synchroniser, persistence filter of FILT_CYCLES clocks and
//               registered rise / fall / mode-qualified edge strobes.
// Ports       : clk, n_rst (async, active-low)
//               i_en         detection enable (low: level tracks, no pulses)
//               i_edge_mode  00 rise, 01 fall, 10 both, 11 none
//               i_async      raw asynchronous input
//               o_level      filtered synchronised level
//               o_rise/o_fall/o_edge  single-cycle strobes
//               i_cnt_clr, o_edge_cnt  only with SD_EDGE_CNT_EN
// Config      : SD_EDGE_CNT_EN adds a saturating 16-bit edge_pulse counter.
// Revision    : 1.0 - initial release
//==============================================================================
module sd_edge_chan
    import sd_edge_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 1,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  wire        clk,
    input  wire        n_rst,
    input  wire        i_en,
    input  wire  [1:0] i_edge_mode,
    input  wire        i_async,
    output logic       o_level,
    output logic       o_rise,
    output logic       o_fall,
    output logic       o_edge
`ifdef SD_EDGE_CNT_EN
    ,
    input  wire                   i_cnt_clr,
    output logic [EDGE_CNT_W-1:0] o_edge_cnt
`endif
);

    localparam int               c_CNT_W    = filt_cnt_w(FILT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_edge;

    edge_mode_t w_mode;
    logic       w_sync_q;
    logic       w_differs;
    logic       w_accept;
    logic       w_rise;
    logic       w_fall;
    logic       w_edge;

    assign w_mode    = edge_mode_t'(i_edge_mode);
    assign w_sync_q  = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_sync_q != r_level);
    // The new level is accepted on the FILT_CYCLES-th consecutive clock it
    // differs from the held level; the strobe is registered on that edge.
    assign w_accept  = i_en && w_differs && (r_cnt == c_CNT_LAST);
    assign w_rise    = w_accept &&  w_sync_q;
    assign w_fall    = w_accept && !w_sync_q;
    assign w_edge    = (w_rise && mode_has_rise(w_mode)) ||
                       (w_fall && mode_has_fall(w_mode));

    // Synchroniser chain; bit 0 captures the pad, the top bit is sync_q.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt   <= '0;
            r_level <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_rise <= w_rise;
            r_fall <= w_fall;
            r_edge <= w_edge;
            if (!i_en) begin
                // Disabled: follow the synchroniser directly so re-enabling
                // never sees a pending difference and cannot pulse.
                r_cnt   <= '0;
                r_level <= w_sync_q;
            end else if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_sync_q;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_edge  = r_edge;

`ifdef SD_EDGE_CNT_EN
    logic [EDGE_CNT_W-1:0] r_edge_cnt;

    // Counts visible edge_pulse strobes; clear has priority over a
    // coincident strobe and the count sticks at all-ones.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_edge_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_edge_cnt <= '0;
        end else if (r_edge && (r_edge_cnt != {EDGE_CNT_W{1'b1}})) begin
            r_edge_cnt <= r_edge_cnt + EDGE_CNT_W'(1);
        end
    end

    assign o_edge_cnt = r_edge_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/sd_edge_detect_multi.sv
`default_nettype none
//==============================================================================
// Module      : sd_edge_detect_multi
// Description : NUM_CH independent synchroniser / glitch filter / edge
//               detector channels for SD-side asynchronous signals.
// Ports       : clk    system clock
//               n_rst  asynchronous reset, active-low
//               bus    sd_edge_detect_multi_if.slave (en, edge_mode,
//                      async_in in; level_out, rise/fall/edge_pulse out;
//                      cnt_clr / edge_cnt with SD_EDGE_CNT_EN)
// Config      : SD_EDGE_CNT_EN adds per-channel saturating edge counters.
// Revision    : 1.0 - initial release
//==============================================================================
module sd_edge_detect_multi
    import sd_edge_pkg::*;
#(
    parameter int   NUM_CH      = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 1,
    parameter logic RESET_LEVEL = 1'b1
) (
    input wire                      clk,
    input wire                      n_rst,
    sd_edge_detect_multi_if.slave   bus
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        sd_edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_chan (
            .clk         (clk),
            .n_rst       (n_rst),
            .i_en        (bus.en),
            .i_edge_mode (bus.edge_mode),
            .i_async     (bus.async_in[g]),
            .o_level     (bus.level_out[g]),
            .o_rise      (bus.rise_pulse[g]),
            .o_fall      (bus.fall_pulse[g]),
            .o_edge      (bus.edge_pulse[g])
`ifdef SD_EDGE_CNT_EN
            ,
            .i_cnt_clr   (bus.cnt_clr),
            .o_edge_cnt  (bus.edge_cnt[g*EDGE_CNT_W +: EDGE_CNT_W])
`endif
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_edge_detect_multi.sv
`default_nettype none
//==============================================================================
// Module      : tb_sd_edge_detect_multi
// Description : Scoreboard bench for sd_edge_detect_multi. Two DUT configs
//               (SYNC 2 / FILT 1 and SYNC 3 / FILT 4) share one stimulus
//               stream; a reference model predicts outputs per clock and a
//               monitor compares them on the falling edge.
// Config      : SD_EDGE_CNT_EN enables the edge counter checks.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_sd_edge_detect_multi;
    import sd_edge_pkg::*;

    localparam int   NCH  = 4;
    localparam int   NCFG = 2;
    localparam int   S0 = 2, F0 = 1;
    localparam int   S1 = 3, F1 = 4;
    localparam logic RL = 1'b1;

    typedef struct {
        logic [NCH-1:0]            lvl;
        logic [NCH-1:0]            rise;
        logic [NCH-1:0]            fall;
        logic [NCH-1:0]            edg;
        logic [NCH*EDGE_CNT_W-1:0] cnt;
    } exp_t;

    logic           clk     = 1'b0;
    logic           n_rst   = 1'b0;
    logic           en      = 1'b1;
    logic [1:0]     mode    = 2'b00;
    logic [NCH-1:0] ain     = '1;
    logic           cnt_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sd_edge_detect_multi_if #(.NUM_CH(NCH)) bus0 ();
    sd_edge_detect_multi_if #(.NUM_CH(NCH)) bus1 ();

    assign bus0.en = en;  assign bus0.edge_mode = mode;  assign bus0.async_in = ain;
    assign bus1.en = en;  assign bus1.edge_mode = mode;  assign bus1.async_in = ain;
`ifdef SD_EDGE_CNT_EN
    assign bus0.cnt_clr = cnt_clr;
    assign bus1.cnt_clr = cnt_clr;
`endif

    sd_edge_detect_multi #(.NUM_CH(NCH), .SYNC_STAGES(S0), .FILT_CYCLES(F0), .RESET_LEVEL(RL))
        u_dut0 (.clk(clk), .n_rst(n_rst), .bus(bus0));
    sd_edge_detect_multi #(.NUM_CH(NCH), .SYNC_STAGES(S1), .FILT_CYCLES(F1), .RESET_LEVEL(RL))
        u_dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1));

    // ---------------- reference model ----------------
    // samp holds raw input samples; an input sampled at edge k is the
    // synchronised value used by the filter at edge k+S.
    logic [NCH-1:0] samp[$];
    logic [NCH-1:0] m_lvl   [NCFG];
    logic [NCH-1:0] m_pedge [NCFG];
    int             m_run   [NCFG][NCH];
    int             m_cnt   [NCFG][NCH];
    exp_t           q0[$];
    exp_t           q1[$];

    function automatic int s_of(input int c); return (c == 0) ? S0 : S1; endfunction
    function automatic int f_of(input int c); return (c == 0) ? F0 : F1; endfunction

    task automatic model_step();
        exp_t           e [NCFG];
        int             s;
        int             f;
        logic [NCH-1:0] sq;
        for (int c = 0; c < NCFG; c++) begin
            e[c].rise = '0; e[c].fall = '0; e[c].edg = '0; e[c].cnt = '0;
        end
        if (!n_rst) begin
            samp.delete();
            for (int c = 0; c < NCFG; c++) begin
                m_lvl[c]   = {NCH{RL}};
                m_pedge[c] = '0;
                for (int ch = 0; ch < NCH; ch++) begin
                    m_run[c][ch] = 0;
                    m_cnt[c][ch] = 0;
                end
                e[c].lvl = m_lvl[c];
            end
        end else begin
            for (int c = 0; c < NCFG; c++) begin
                s  = s_of(c);
                f  = f_of(c);
                sq = (samp.size() >= s) ? samp[samp.size() - s] : {NCH{RL}};
                for (int ch = 0; ch < NCH; ch++) begin
                    if (cnt_clr)
                        m_cnt[c][ch] = 0;
                    else if (m_pedge[c][ch] && m_cnt[c][ch] < 65535)
                        m_cnt[c][ch] = m_cnt[c][ch] + 1;
                    if (!en) begin
                        m_lvl[c][ch] = sq[ch];
                        m_run[c][ch] = 0;
                    end else if (sq[ch] == m_lvl[c][ch]) begin
                        m_run[c][ch] = 0;
                    end else if (m_run[c][ch] + 1 == f) begin
                        m_lvl[c][ch] = sq[ch];
                        m_run[c][ch] = 0;
                        if (sq[ch]) e[c].rise[ch] = 1'b1;
                        else        e[c].fall[ch] = 1'b1;
                    end else begin
                        m_run[c][ch] = m_run[c][ch] + 1;
                    end
                    e[c].edg[ch] = (e[c].rise[ch] && (mode == 2'd0 || mode == 2'd2)) ||
                                   (e[c].fall[ch] && (mode == 2'd1 || mode == 2'd2));
                    e[c].cnt[ch*EDGE_CNT_W +: EDGE_CNT_W] = 16'(m_cnt[c][ch]);
                end
                m_pedge[c] = e[c].edg;
                e[c].lvl   = m_lvl[c];
            end
            samp.push_back(ain);
            if (samp.size() > 8) void'(samp.pop_front());
        end
        q0.push_back(e[0]);
        q1.push_back(e[1]);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int rc [NCFG][NCH];
    int fc [NCFG][NCH];
    int ec [NCFG][NCH];

    task automatic cmp_out(input int c, input exp_t e, input logic [NCH-1:0] lv,
                           input logic [NCH-1:0] ri, input logic [NCH-1:0] fa,
                           input logic [NCH-1:0] ed);
        n_cmp++;
        if ({lv, ri, fa, ed} !== {e.lvl, e.rise, e.fall, e.edg}) begin
            n_bad++;
            $display("FAIL cfg%0d outputs t=%0t: got lvl=%h rise=%h fall=%h edge=%h, want lvl=%h rise=%h fall=%h edge=%h",
                     c, $time, lv, ri, fa, ed, e.lvl, e.rise, e.fall, e.edg);
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        for (int c = 0; c < NCFG; c++)
            for (int ch = 0; ch < NCH; ch++) begin
                rc[c][ch] = 0; fc[c][ch] = 0; ec[c][ch] = 0;
            end
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp_out(0, e, bus0.level_out, bus0.rise_pulse, bus0.fall_pulse, bus0.edge_pulse);
`ifdef SD_EDGE_CNT_EN
                n_cmp++;
                if (bus0.edge_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL cfg0 edge_cnt t=%0t: got %h, want %h", $time, bus0.edge_cnt, e.cnt);
                end
`endif
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp_out(1, e, bus1.level_out, bus1.rise_pulse, bus1.fall_pulse, bus1.edge_pulse);
`ifdef SD_EDGE_CNT_EN
                n_cmp++;
                if (bus1.edge_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL cfg1 edge_cnt t=%0t: got %h, want %h", $time, bus1.edge_cnt, e.cnt);
                end
`endif
            end
            for (int ch = 0; ch < NCH; ch++) begin
                rc[0][ch] += int'(bus0.rise_pulse[ch]);
                fc[0][ch] += int'(bus0.fall_pulse[ch]);
                ec[0][ch] += int'(bus0.edge_pulse[ch]);
                rc[1][ch] += int'(bus1.rise_pulse[ch]);
                fc[1][ch] += int'(bus1.fall_pulse[ch]);
                ec[1][ch] += int'(bus1.edge_pulse[ch]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int br, bf, be, br1, bf1, be1;
        int exp_edge [4];
        logic [EDGE_CNT_W-1:0] cval;
        exp_edge[0] = 2; exp_edge[1] = 2; exp_edge[2] = 4; exp_edge[3] = 0;

        // Reset with all inputs idle-high.
        cyc(3);
        chk("reset level cfg0", longint'(bus0.level_out), 15);
        chk("reset pulses cfg1", longint'({bus1.rise_pulse, bus1.fall_pulse, bus1.edge_pulse}), 0);
        n_rst = 1'b1;
        cyc(6);

        // FILT=1: ch0 1->0->1, rise mode.
        br = rc[0][0]; bf = fc[0][0]; be = ec[0][0];
        ain[0] = 1'b0; cyc(5);
        ain[0] = 1'b1; cyc(9);
        chk("f1 ch0 rise count", rc[0][0] - br, 1);
        chk("f1 ch0 fall count", fc[0][0] - bf, 1);
        chk("f1 ch0 edge count (rise mode)", ec[0][0] - be, 1);

        // FILT=4: 3-cycle glitch rejected, 4-cycle low accepted.
        bf1 = fc[1][1];
        ain[1] = 1'b0; cyc(3);
        ain[1] = 1'b1; cyc(10);
        chk("f4 glitch fall count", fc[1][1] - bf1, 0);
        chk("f4 glitch level", longint'(bus1.level_out[1]), 1);
        ain[1] = 1'b0; cyc(4);
        ain[1] = 1'b1; cyc(1);
        ain[1] = 1'b0; cyc(10);
        chk("f4 hold fall count", fc[1][1] - bf1, 1);
        chk("f4 hold level", longint'(bus1.level_out[1]), 0);
        ain[1] = 1'b1; cyc(10);

        // Edge mode sweep on ch2 (4 toggles each).
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            cyc(3);
            br = rc[0][2]; bf = fc[0][2]; be = ec[0][2];
            for (int t = 0; t < 4; t++) begin
                ain[2] = ~ain[2];
                cyc(5);
            end
            cyc(5);
            chk($sformatf("mode%0d edge count", m), ec[0][2] - be, exp_edge[m]);
            chk($sformatf("mode%0d rise count", m), rc[0][2] - br, 2);
            chk($sformatf("mode%0d fall count", m), fc[0][2] - bf, 2);
        end

        // Disabled detection while ch3 toggles.
        mode = 2'd2;
        en = 1'b0; cyc(2);
        br = rc[0][3] + fc[0][3]; br1 = rc[1][3] + fc[1][3];
        for (int t = 0; t < 5; t++) begin
            ain[3] = ~ain[3];
            cyc(2);
        end
        cyc(6);
        chk("en low pulses cfg0", rc[0][3] + fc[0][3] - br, 0);
        chk("en low pulses cfg1", rc[1][3] + fc[1][3] - br1, 0);
        chk("en low level tracks", longint'(bus1.level_out[3]), 0);
        en = 1'b1; cyc(10);
        chk("en high no pulse cfg0", rc[0][3] + fc[0][3] - br, 0);
        chk("en high no pulse cfg1", rc[1][3] + fc[1][3] - br1, 0);

        // Reset in the middle of a FILT=4 acceptance.
        ain = '0; cyc(12);
        ain[1:0] = 2'b11; cyc(5);
        n_rst = 1'b0; #1;
        chk("async reset level cfg1", longint'(bus1.level_out), 15);
        chk("async reset level cfg0", longint'(bus0.level_out), 15);
        chk("async reset pulses", longint'({bus0.rise_pulse, bus0.fall_pulse, bus1.rise_pulse, bus1.fall_pulse}), 0);
        ain = '1;
        cyc(2);
        n_rst = 1'b1;
        cyc(5);

        // Randomised traffic including occasional resets.
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < NCH; b++)
                if ($urandom_range(5) == 0) ain[b] = ~ain[b];
            if ($urandom_range(49) == 0) en = ~en;
            if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
            cnt_clr = ($urandom_range(99) == 0);
            n_rst   = ($urandom_range(299) != 0);
            cyc(1);
        end
        n_rst = 1'b1; en = 1'b1; cnt_clr = 1'b0; mode = 2'd2;
        cyc(10);

`ifdef SD_EDGE_CNT_EN
        // Saturate ch0 counter, then clear on a cycle with a live edge.
        for (int i = 0; i < 65545; i++) begin
            ain[0] = ~ain[0];
            cyc(1);
        end
        cval = bus0.edge_cnt[EDGE_CNT_W-1:0];
        chk("edge_cnt saturated", longint'(cval), 65535);
        chk("edge pulse live before clear", longint'(bus0.edge_pulse[0]), 1);
        cnt_clr = 1'b1;
        ain[0] = ~ain[0];
        @(posedge clk); #1;
        cval = bus0.edge_cnt[EDGE_CNT_W-1:0];
        chk("edge_cnt clear wins", longint'(cval), 0);
        cnt_clr = 1'b0;
        cyc(3);
`endif

        cyc(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_edge_detect_multi.md
Name: sd_edge_detect_multi

Overview:
Parametrised multi-channel synchroniser, glitch filter and edge detector for SD-side asynchronous signals such as sclk, cmd and dat lines. Each channel synchronises its input into clk, rejects pulses shorter than FILT_CYCLES, and emits single-cycle rise, fall and mode-qualified edge strobes. It sits between the SD pads and the SD command/data FSMs, and replaces the single-channel sclk edge detector.

Parameters:
NUM_CH, 4, number of independent input channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (2..4)
FILT_CYCLES, 1, consecutive clk cycles a new level must persist before acceptance (1..255; 1 = no filtering)
RESET_LEVEL, 1'b1, reset value of sync chain and filtered level (idle-high bus)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous reset, active-low
en  in  1  detection enable
edge_mode  in  2  00 rise, 01 fall, 10 both, 11 none; global to all channels
async_in  in  NUM_CH  raw asynchronous inputs
level_out  out  NUM_CH  filtered, synchronised level
rise_pulse  out  NUM_CH  1-cycle strobe on accepted 0->1
fall_pulse  out  NUM_CH  1-cycle strobe on accepted 1->0
edge_pulse  out  NUM_CH  rise/fall strobe qualified by edge_mode

Behaviour:
- Reset (n_rst low, async): every sync flop = RESET_LEVEL; level_out = RESET_LEVEL on all bits; filter counters = 0; all pulses = 0. No pulse is generated on reset release if the inputs equal RESET_LEVEL.
- Sync: shift chain of SYNC_STAGES flops; sync_q is the last stage.
- Filter, per channel: cnt has width clog2(FILT_CYCLES+1).
  - sync_q == level_out: cnt <= 0.
  - sync_q != level_out and cnt == FILT_CYCLES-1: level_out <= sync_q, cnt <= 0, and the matching rise/fall pulse is registered high for exactly this cycle.
  - Otherwise: cnt <= cnt + 1.
  - A glitch that reverts before acceptance resets cnt; no level change, no pulse.
- Latency: after an input change is first captured, level_out and its pulse update together SYNC_STAGES + FILT_CYCLES - 1 edges later. All outputs are registered.
- edge_pulse = (rise_pulse & mode∈{00,10}) | (fall_pulse & mode∈{01,10}). Mode 11 forces 0. edge_pulse is registered with the rise/fall pulses, and edge_mode is sampled on the same edge.
- en low: cnt held at 0; level_out <= sync_q each cycle (tracks without filter); all pulses forced 0.
- en high again: no spurious pulse, because level_out already equals sync_q.
- Pulse spacing: consecutive pulses on a channel are at least FILT_CYCLES cycles apart; at FILT_CYCLES=1 toggling every cycle produces alternating rise/fall pulses.
- Channels are fully independent; simultaneous edges on several channels all pulse in the same cycle.

Optional Feature:
- Macro: SD_EDGE_CNT_EN.
- Defined:
  - Adds input cnt_clr (1) and output edge_cnt (NUM_CH*16).
  - Each channel has a 16-bit counter that increments on its edge_pulse and saturates at 16'hFFFF.
  - cnt_clr zeroes all counters synchronously and wins over a same-cycle edge, so the result is 0.
  - Counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is unchanged.

Decomposition:
- Package sd_edge_pkg:
  - typedef edge_mode_t enum {EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_NONE=2'b11}.
  - Constant EDGE_CNT_W=16.
  - Localparam helper for the filter counter width.
- Sub-module sd_edge_chan: one channel's sync, filter and pulse logic (plus the counter under the macro). The top instantiates it NUM_CH times in a generate loop and ORs nothing across channels.

Test Plan:
- Reset with async_in=all 1: level_out=all 1 and no pulses during or after release.
- SYNC_STAGES=2, FILT_CYCLES=1, mode=00: ch0 1->0->1 held 5 cycles each. fall_pulse[0] high 1 cycle at 2 edges after first capture; rise_pulse[0] and edge_pulse[0] high 1 cycle 2 edges after the 0->1 capture; fall does not drive edge_pulse.
- FILT_CYCLES=4: ch1 0-glitch of 3 cycles gives no pulse and level stays 1; 0 held 4 cycles gives one fall_pulse at SYNC_STAGES+3 edges; level_out[1]=0.
- mode sweep 00/01/10/11 on a 4-edge toggle of ch2: edge_pulse counts 2/2/4/0; rise/fall pulses are 2/2 in every mode.
- en low while ch3 toggles: no pulses and level_out tracks sync_q; en high with stable input gives no pulse. Assert n_rst mid-filter (cnt=2): immediate return to reset values.
- SD_EDGE_CNT_EN: preload near saturation via 65537 ch0 edges, count holds at 16'hFFFF; cnt_clr coincident with an edge gives edge_cnt[0]=0.
